// File: rtl/ram_ctrl.sv
// Single-port synchronous RAM behind a valid/ready request port with a registered response.
// Define RAM_CTRL_INDIRECT_EN to enable indirect (mem[mem[addr]]) addressing through the PTR state.
`timescale 1ns/1ps

module ram_ctrl #(
  parameter int ADDR_WIDTH = 13,
  parameter int DATA_WIDTH = 8,
  parameter int LENGTH     = 1 << ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic                  req_ind,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err
);

  localparam int IDX_W = (LENGTH > 1) ? $clog2(LENGTH) : 1;
  localparam logic [ADDR_WIDTH:0] LIMIT = (ADDR_WIDTH + 1)'(LENGTH);

`ifdef RAM_CTRL_INDIRECT_EN
  typedef enum logic [1:0] {IDLE = 2'd0, PTR = 2'd1, ACCESS = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd2} state_t;
`endif

  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
    return {1'b0, a} < LIMIT;
  endfunction

  logic [DATA_WIDTH-1:0] mem [0:LENGTH-1];

  state_t                state_reg;
  logic                  we_reg;
  logic [ADDR_WIDTH-1:0] addr_reg;
  logic [DATA_WIDTH-1:0] wdata_reg;
  logic                  rsp_valid_reg;
  logic [DATA_WIDTH-1:0] rsp_rdata_reg;
  logic                  rsp_err_reg;
  logic [ADDR_WIDTH-1:0] ea;
  logic                  ea_ok;
  logic                  wr_en;

`ifdef RAM_CTRL_INDIRECT_EN
  logic                  ind_reg;
  logic [ADDR_WIDTH-1:0] ptr_reg;
  logic                  perr_reg;

  // A pointer fetched from an out-of-range address poisons the access.
  always_comb begin
    ea    = ind_reg ? ptr_reg : addr_reg;
    ea_ok = in_range(ea) && !(ind_reg && perr_reg);
  end
`else
  logic unused_ind;
  assign unused_ind = req_ind;

  always_comb begin
    ea    = addr_reg;
    ea_ok = in_range(ea);
  end
`endif

  assign wr_en     = (state_reg == ACCESS) && we_reg && ea_ok;
  assign req_ready = (state_reg == IDLE) && rst_n;
  assign rsp_valid = rsp_valid_reg;
  assign rsp_rdata = rsp_rdata_reg;
  assign rsp_err   = rsp_err_reg;

  // Memory array carries no reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[ea[IDX_W-1:0]] <= wdata_reg;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      we_reg        <= 1'b0;
      addr_reg      <= '0;
      wdata_reg     <= '0;
      rsp_valid_reg <= 1'b0;
      rsp_rdata_reg <= '0;
      rsp_err_reg   <= 1'b0;
`ifdef RAM_CTRL_INDIRECT_EN
      ind_reg       <= 1'b0;
      ptr_reg       <= '0;
      perr_reg      <= 1'b0;
`endif
    end else begin
      rsp_valid_reg <= 1'b0;
      rsp_err_reg   <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (req_valid) begin
            we_reg    <= req_we;
            addr_reg  <= req_addr;
            wdata_reg <= req_wdata;
`ifdef RAM_CTRL_INDIRECT_EN
            ind_reg   <= req_ind;
            perr_reg  <= 1'b0;
            state_reg <= req_ind ? PTR : ACCESS;
`else
            state_reg <= ACCESS;
`endif
          end
        end
`ifdef RAM_CTRL_INDIRECT_EN
        PTR: begin
          perr_reg <= !in_range(addr_reg);
          if (in_range(addr_reg)) begin
            ptr_reg <= ADDR_WIDTH'(mem[addr_reg[IDX_W-1:0]]);
          end
          state_reg <= ACCESS;
        end
`endif
        ACCESS: begin
          rsp_valid_reg <= 1'b1;
          rsp_err_reg   <= !ea_ok;
          if (!we_reg) begin
            rsp_rdata_reg <= ea_ok ? mem[ea[IDX_W-1:0]] : '0;
          end
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule
